unstacker_arbiter: RTL

- Round-robin arbiter that shares one 128-bit-to-32-bit word serialisation path between NUM_REQ block producers in the AES HWPE datapath.
- Example producers: cipher output, IV/state readback.
- Accepts one whole 128-bit block from the granted requester and emits it as 4 × 32-bit beats over a valid/ready stream, each beat tagged with the source id.
- Sits between the AES core outputs and the streamer sink.

---
 rtl/unstacker_arb_pkg.sv | 17 +
 rtl/unstacker_arbiter_rr_picker.sv | 38 +++
 rtl/unstacker_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/unstacker_arb_pkg.sv
// Shared types and constants for the block-to-word unstacker arbiter.
package unstacker_arb_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int BEATS   = BLOCK_W / WORD_W;
    localparam int BEAT_W  = $clog2(BEATS);
    localparam int WORD_SH = $clog2(WORD_W);

    typedef enum logic {
        ARB_IDLE,
        ARB_SEND
    } arb_state_e;

    typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/unstacker_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr_i, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               any_o
);

    logic found;

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        // Upper segment [ptr_i, NUM_REQ) is searched first, then the wrapped segment.
        for (int n = 0; n < NUM_REQ; n++) begin
            if (!found && req_i[n] && (n >= int'(ptr_i))) begin
                found     = 1'b1;
                gnt_o[n]  = 1'b1;
                gnt_idx_o = ID_W'(n);
            end
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (!found && req_i[n]) begin
                found     = 1'b1;
                gnt_o[n]  = 1'b1;
                gnt_idx_o = ID_W'(n);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/unstacker_arbiter.sv
// Round-robin arbiter that serialises one 128-bit block into four 32-bit beats.
// Build option UNSTACKER_ARB_LSW_FIRST_EN: emit least-significant word first.
module unstacker_arbiter
    import unstacker_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WORD_W-1:0]          word_o,
    output logic [ID_W-1:0]            src_o,
    output logic                       last_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           blk_cnt_o
);

    arb_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    block_t           block_q, block_d;
    logic [ID_W-1:0]  src_q, src_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               sending, handshake, last_beat, grant;
    logic [WORD_W-1:0]  word_sel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    assign sending   = (state_q == ARB_SEND);
    assign handshake = sending && ready_i;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    // A new block may be taken while idle or on the final beat's handshake, so blocks stream without a bubble.
    assign grant     = !rst_i && !clr_i && enable_i && gnt_any
                       && (!sending || (handshake && last_beat));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        block_d  = block_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;

        if (handshake) begin
            beat_d = beat_q + BEAT_W'(1);
            if (last_beat) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ARB_IDLE;
            end
        end

        if (grant) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                if (gnt[n]) begin
                    block_d = req_data_i[n*BLOCK_W +: BLOCK_W];
                end
            end
            src_d    = gnt_idx;
            beat_d   = '0;
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            state_d  = ARB_SEND;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q  <= ARB_IDLE;
            beat_q   <= '0;
            // NOTE: the block register is cleared too, so a discarded block never survives a reset or clear.
            block_q  <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            block_q  <= block_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef UNSTACKER_ARB_LSW_FIRST_EN
    assign word_sel = block_q[{beat_q, {WORD_SH{1'b0}}} +: WORD_W];
`else
    // Inverting the beat index walks the block from [127:96] downwards.
    assign word_sel = block_q[{~beat_q, {WORD_SH{1'b0}}} +: WORD_W];
`endif

    assign req_ready_o = grant ? gnt : '0;
    assign valid_o     = sending;
    assign busy_o      = sending;
    assign last_o      = sending && last_beat;
    assign word_o      = sending ? word_sel : '0;
    assign src_o       = src_q;
    assign blk_cnt_o   = cnt_q;

endmodule
